// File: rtl/im_pkg.sv
// Shared constants and types for the instruction-memory fetch unit.
package im_pkg;

    localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
    localparam logic [1:0]  FAULT_RANGE    = 2'b10;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/im_ram.sv
// Single-write-port, synchronous-read, write-first instruction RAM.
module im_ram #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = "",
    localparam int   IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write to the word being read wins over the stored value.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/im_fetch_unit.sv
// Instruction fetch unit: 1-cycle registered fetch with valid/ready on both sides.
// Define IM_PERF_EN to add the fetch_cnt / fault_cnt performance counters.
module im_fetch_unit
    import im_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter string             INIT_FILE = "",
    localparam int               IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic [1:0]        rsp_fault,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_addr,
    input  logic [DATA_W-1:0] prog_data
`ifdef IM_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       fault_cnt
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        fault_q, fault_d;
    logic              loaded_q, loaded_d;

    logic              accept;
    logic              load;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] idx_full;
    logic              misalign;
    logic              out_of_range;
    logic [1:0]        req_fault;
    logic [DATA_W-1:0] ram_rdata;

    // Address decode; a faulting request never touches the RAM.
    always_comb begin
        offset       = req_addr - BASE_ADDR;
        idx_full     = offset >> 2;
        misalign     = (req_addr[1:0] != 2'b00);
        out_of_range = (req_addr < BASE_ADDR) || (idx_full >= ADDR_W'(DEPTH));
        req_fault    = (misalign ? FAULT_MISALIGN : 2'b00) |
                       (out_of_range ? FAULT_RANGE : 2'b00);
    end

    assign accept = req_valid && req_ready;
    assign load   = accept && !flush;

    im_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (load && (req_fault == 2'b00)),
        .raddr (idx_full[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            pc_q     <= '0;
            fault_q  <= 2'b00;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fault_q  <= fault_d;
            loaded_q <= loaded_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   state_d = load ? FULL : EMPTY;
                FULL:    state_d = load ? FULL : (rsp_ready ? EMPTY : FULL);
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        rsp_valid = (state_q == FULL);
        req_ready = !rsp_valid || rsp_ready;
    end

    always_comb begin
        pc_d     = pc_q;
        fault_d  = fault_q;
        loaded_d = loaded_q;
        if (load) begin
            pc_d     = req_addr;
            fault_d  = req_fault;
            loaded_d = (req_fault == 2'b00);
        end
    end

    // loaded_q masks the un-reset RAM output and forces NOP for faulted fetches.
    assign rsp_instr = loaded_q ? ram_rdata : DATA_W'(NOP_INSTR);
    assign rsp_pc    = pc_q;
    assign rsp_fault = fault_q;

`ifdef IM_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] fault_cnt_q, fault_cnt_d;
    logic        handshake;

    assign handshake = rsp_valid && rsp_ready;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        fault_cnt_d = fault_cnt_q;
        if (handshake && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (handshake && (fault_q != 2'b00) && (fault_cnt_q != 32'hFFFF_FFFF)) begin
            fault_cnt_d = fault_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            fault_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign fault_cnt = fault_cnt_q;
`endif

endmodule
